// File: rtl/audio_pkg.sv
// audio_pkg: shared constants and types for the audio framer.
//   DW        - default sample width in bits
//   FRAME_LEN - default samples per frame (power of two)
//   HOP       - default new samples between frame starts (power of two, <= FRAME_LEN)
//   AW        - address width of the 2*FRAME_LEN circular buffer
//   framer_state_t - framer FSM state encoding
`timescale 1ns/1ps
package audio_pkg;

  localparam int DW        = 16;
  localparam int FRAME_LEN = 256;
  localparam int HOP       = 128;

  // The buffer holds two frames, so addresses span 2*frame_len entries.
  function automatic int addr_width(input int frame_len);
    return $clog2(2 * frame_len);
  endfunction

  localparam int AW = addr_width(FRAME_LEN);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2
  } framer_state_t;

endpackage

// File: rtl/framer_ram.sv
// framer_ram: simple dual-port sample buffer, one write port and one
// synchronous read port with 1-cycle latency.
// Ports:
//   clk     - clock, rising edge
//   rst     - synchronous active-high clear of the read data register only
//   we      - write enable
//   wr_addr - write address
//   wr_data - write data
//   re      - read enable; rd_data holds its value while re is 0
//   rd_addr - read address
//   rd_data - registered read data
`timescale 1ns/1ps
module framer_ram
  import audio_pkg::*;
#(
  parameter int ADDR_W = AW,
  parameter int DATA_W = DW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Storage itself is never cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // The read register doubles as the framer's output sample register, so
  // it is cleared on reset and only updated on an explicit read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (re) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/audio_framer.sv
// audio_framer: cuts a continuous mono PCM stream into overlapping frames of
// FRAME_LEN samples, a new frame every HOP samples, and streams each frame
// out over a valid/ready interface.
// Ports:
//   mclk       - sole clock, rising edge
//   rst        - synchronous active-high reset
//   in_sample  - input sample (DW bits)
//   in_valid   - one-cycle input strobe, no backpressure
//   out_sample - framed output sample (DW bits)
//   out_valid  - out_sample holds valid data
//   out_ready  - consumer accepts; transfer when out_valid && out_ready
//   out_first  - current output is sample 0 of a frame
//   out_last   - current output is sample FRAME_LEN-1 of a frame
//   drop       - one-cycle pulse when a frame trigger is discarded
//   drop_count - dropped frame count, saturating at 255
`timescale 1ns/1ps
module audio_framer #(
  parameter int DW        = audio_pkg::DW,
  parameter int FRAME_LEN = audio_pkg::FRAME_LEN,
  parameter int HOP       = audio_pkg::HOP
) (
  input  logic          mclk,
  input  logic          rst,
  input  logic [DW-1:0] in_sample,
  input  logic          in_valid,
  output logic [DW-1:0] out_sample,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_first,
  output logic          out_last,
  output logic          drop,
  output logic [7:0]    drop_count
);
  import audio_pkg::*;

  localparam int ADDR_W = addr_width(FRAME_LEN);
  localparam int FILL_W = $clog2(FRAME_LEN + 1);
  localparam int HOP_W  = (HOP > 1) ? $clog2(HOP) : 1;
  localparam int IDX_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  localparam logic [ADDR_W-1:0] FRAME_OFS = ADDR_W'(FRAME_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(FRAME_LEN);
  localparam logic [FILL_W-1:0] FILL_TRIG = FILL_W'(FRAME_LEN - 1);
  localparam logic [HOP_W-1:0]  HOP_MAX   = HOP_W'(HOP - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(FRAME_LEN - 1);

  framer_state_t     state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] rd_addr;
  logic [FILL_W-1:0] fill;
  logic [HOP_W-1:0]  hop_cnt;
  logic [IDX_W-1:0]  idx;
  logic              trigger;
  logic              xfer;
  logic              last_xfer;
  logic              rd_en;

  // A frame is due on the write that completes the first FRAME_LEN samples,
  // and afterwards on every write that wraps the hop counter.
  assign trigger = in_valid &&
                   ((fill == FILL_TRIG) || ((fill == FILL_MAX) && (hop_cnt == HOP_MAX)));

  // out_valid is only ever high in STREAM, so a transfer implies STREAM.
  assign xfer      = out_valid && out_ready;
  assign last_xfer = xfer && out_last;

  // LOAD fetches the first sample; each non-final transfer pre-reads the next
  // one so samples can leave back-to-back.
  assign rd_en   = (state == ST_LOAD) || (xfer && !out_last);
  assign rd_addr = (state == ST_LOAD) ? rd_ptr : rd_ptr + 1'b1;

  framer_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DW)
  ) u_ram (
    .clk     (mclk),
    .rst     (rst),
    .we      (in_valid),
    .wr_addr (wr_ptr),
    .wr_data (in_sample),
    .re      (rd_en),
    .rd_addr (rd_addr),
    .rd_data (out_sample)
  );

  // Write side: the hop counter only runs once the first frame's worth of
  // samples has been collected.
  always_ff @(posedge mclk) begin
    if (rst) begin
      wr_ptr  <= '0;
      fill    <= '0;
      hop_cnt <= '0;
    end else if (in_valid) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (fill != FILL_MAX) begin
        fill <= fill + 1'b1;
      end else begin
        hop_cnt <= (hop_cnt == HOP_MAX) ? '0 : hop_cnt + 1'b1;
      end
    end
  end

  // Read side FSM. rd_ptr always addresses the sample currently presented;
  // the frame start is the oldest of the last FRAME_LEN written samples.
  always_ff @(posedge mclk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rd_ptr     <= '0;
      idx        <= '0;
      out_valid  <= 1'b0;
      out_first  <= 1'b0;
      out_last   <= 1'b0;
      drop       <= 1'b0;
      drop_count <= '0;
    end else begin
      drop <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (trigger) begin
            rd_ptr <= wr_ptr + 1'b1 - FRAME_OFS;
            state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          state     <= ST_STREAM;
          out_valid <= 1'b1;
          out_first <= 1'b1;
          out_last  <= (FRAME_LEN == 1);
          idx       <= '0;
        end
        ST_STREAM: begin
          if (xfer) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_first <= 1'b0;
              out_last  <= 1'b0;
              // A trigger coinciding with the final transfer starts the next
              // frame directly instead of being dropped.
              if (trigger) begin
                rd_ptr <= wr_ptr + 1'b1 - FRAME_OFS;
                state  <= ST_LOAD;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              rd_ptr    <= rd_ptr + 1'b1;
              idx       <= idx + 1'b1;
              out_first <= 1'b0;
              out_last  <= ((idx + 1'b1) == IDX_LAST);
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      // Any trigger while a frame is pending or in flight is discarded,
      // except the one absorbed by the final transfer above.
      if (trigger && (state != ST_IDLE) && !last_xfer) begin
        drop <= 1'b1;
        if (drop_count != 8'hFF) begin
          drop_count <= drop_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_framer.sv
// tb_audio_framer: directed self-checking bench for audio_framer with the
// default parameters (DW=16, FRAME_LEN=256, HOP=128). Input samples carry
// their own index (or index+1000 after the mid-frame reset), so every
// expected output value is a frame start plus a position.
`timescale 1ns/1ps
module tb_audio_framer;
  import audio_pkg::*;

  localparam int STRIDE  = 4;
  localparam int TIMEOUT = 20000;

  logic          mclk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_sample = '0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_sample;
  logic          out_valid;
  logic          out_first;
  logic          out_last;
  logic          drop;
  logic [7:0]    drop_count;

  int checks = 0;
  int errors = 0;

  int exp_q[$];
  int exp_start = 0;
  int mon_idx = 0;
  int frames_done = 0;
  int drops_seen = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_sample = '0;
  logic          prev_first = 1'b0;
  logic          prev_last = 1'b0;
  logic          rand_ready = 1'b0;

  audio_framer #(
    .DW        (DW),
    .FRAME_LEN (FRAME_LEN),
    .HOP       (HOP)
  ) dut (
    .mclk       (mclk),
    .rst        (rst),
    .in_sample  (in_sample),
    .in_valid   (in_valid),
    .out_sample (out_sample),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_first  (out_first),
    .out_last   (out_last),
    .drop       (drop),
    .drop_count (drop_count)
  );

  always #5 mclk = ~mclk;

  task automatic check_output(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Scoreboard: each transfer is compared against the next expected frame
  // start plus its position; stalled outputs must not move.
  always @(negedge mclk) begin
    if (rst) begin
      mon_idx    = 0;
      prev_stall = 1'b0;
    end else begin
      if (out_valid && prev_stall) begin
        check_output("stall_sample", int'(out_sample), int'(prev_sample));
        check_output("stall_first", int'(out_first), int'(prev_first));
        check_output("stall_last", int'(out_last), int'(prev_last));
      end
      if (out_valid && out_ready) begin
        if (mon_idx == 0) begin
          if (exp_q.size() == 0) begin
            check_output("unexpected_frame", int'(out_sample), -1);
            exp_start = int'(out_sample);
          end else begin
            exp_start = exp_q.pop_front();
          end
        end
        check_output("sample", int'(out_sample), exp_start + mon_idx);
        check_output("first", int'(out_first), int'(mon_idx == 0));
        check_output("last", int'(out_last), int'(mon_idx == FRAME_LEN - 1));
        if (mon_idx == FRAME_LEN - 1) begin
          mon_idx = 0;
          frames_done++;
        end else begin
          mon_idx++;
        end
      end
      prev_stall  = out_valid && !out_ready;
      prev_sample = out_sample;
      prev_first  = out_first;
      prev_last   = out_last;
      if (drop) drops_seen++;
    end
  end

  // Random consumer, 50% ready, active only when the main sequence asks.
  initial begin
    forever begin
      @(posedge mclk);
      #2;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge mclk);
      #1;
    end
  endtask

  task automatic write_sample(input int v);
    in_sample = DW'(v);
    in_valid  = 1'b1;
    @(posedge mclk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic apply_sample(input int v, input int stride);
    write_sample(v);
    idle(stride - 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
  endtask

  task automatic wait_frames(input int target, input string tag);
    int n = 0;
    while (frames_done < target && n < TIMEOUT) begin
      @(posedge mclk);
      n++;
    end
    #1;
    check_output(tag, frames_done, target);
  endtask

  initial begin
    int ds;

    // Reset state
    idle(3);
    check_output("rst_out_valid", int'(out_valid), 0);
    check_output("rst_out_first", int'(out_first), 0);
    check_output("rst_out_last", int'(out_last), 0);
    check_output("rst_drop", int'(drop), 0);
    check_output("rst_out_sample", int'(out_sample), 0);
    check_output("rst_drop_count", int'(drop_count), 0);
    rst = 1'b0;
    idle(1);

    // Ramp with out_ready=1, long enough for wr_ptr to wrap twice.
    // Triggers at writes 255+128k up to 1151 give frames starting 0..896.
    $display("[TB] ramp, out_ready=1");
    out_ready   = 1'b1;
    frames_done = 0;
    for (int k = 0; k < 8; k++) exp_q.push_back(k * 128);
    for (int v = 0; v < 255; v++) apply_sample(v, STRIDE);
    check_output("no_early_frame", int'(out_valid), 0);
    write_sample(255);
    check_output("lat_t1_valid", int'(out_valid), 0);
    idle(1);
    check_output("lat_t2_valid", int'(out_valid), 1);
    check_output("lat_t2_first", int'(out_first), 1);
    check_output("lat_t2_sample", int'(out_sample), 0);
    idle(STRIDE - 2);
    for (int v = 256; v < 1152; v++) apply_sample(v, STRIDE);
    wait_frames(8, "ramp_frames");
    check_output("ramp_queue", exp_q.size(), 0);
    check_output("ramp_drop_count", int'(drop_count), 0);

    // Random 50% out_ready, slower input so frames never collide.
    $display("[TB] random out_ready");
    do_reset();
    frames_done = 0;
    ds = drops_seen;
    for (int k = 0; k < 5; k++) exp_q.push_back(k * 128);
    rand_ready = 1'b1;
    for (int v = 0; v < 768; v++) apply_sample(v, 8);
    wait_frames(5, "rand_frames");
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    idle(1);
    check_output("rand_drops_seen", drops_seen - ds, 0);
    check_output("rand_drop_count", int'(drop_count), 0);
    check_output("rand_queue", exp_q.size(), 0);

    // Consumer stalled through frame 0: triggers at 383 and 511 are dropped;
    // the next frame is the one triggered by sample 639 (384..639).
    $display("[TB] stalled consumer, drops");
    out_ready = 1'b0;
    do_reset();
    frames_done = 0;
    exp_q.push_back(0);
    exp_q.push_back(384);
    for (int v = 0; v < 512; v++) begin
      write_sample(v);
      if (v == 255) begin
        check_output("stall_trig_drop", int'(drop), 0);
      end else if (v == 383) begin
        check_output("drop_383", int'(drop), 1);
        check_output("drop_count_383", int'(drop_count), 1);
      end else if (v == 511) begin
        check_output("drop_511", int'(drop), 1);
        check_output("drop_count_511", int'(drop_count), 2);
      end
      idle(1);
      if (v == 383) check_output("drop_one_cycle", int'(drop), 0);
      idle(STRIDE - 2);
    end
    check_output("held_valid", int'(out_valid), 1);
    check_output("held_sample", int'(out_sample), 0);
    out_ready = 1'b1;
    for (int v = 512; v < 700; v++) apply_sample(v, STRIDE);
    wait_frames(2, "drop_frames");
    check_output("drop_count_final", int'(drop_count), 2);
    check_output("drop_queue", exp_q.size(), 0);

    // Last transfer of frame 0 lands exactly on the write of sample 383.
    $display("[TB] last transfer aligned with trigger");
    out_ready = 1'b0;
    do_reset();
    frames_done = 0;
    ds = drops_seen;
    exp_q.push_back(0);
    exp_q.push_back(128);
    for (int v = 0; v < 256; v++) apply_sample(v, STRIDE);
    fork
      begin
        for (int v = 256; v < 384; v++) apply_sample(v, STRIDE);
      end
      begin
        idle(256 - (STRIDE - 1));
        out_ready = 1'b1;
        idle(256);
        check_output("align_drop", int'(drop), 0);
        check_output("align_load_valid", int'(out_valid), 0);
        idle(1);
        check_output("align_valid", int'(out_valid), 1);
        check_output("align_first", int'(out_first), 1);
        check_output("align_sample", int'(out_sample), 128);
      end
    join
    wait_frames(2, "align_frames");
    check_output("align_drops_seen", drops_seen - ds, 0);
    check_output("align_drop_count", int'(drop_count), 0);

    // Reset in the middle of a streaming frame.
    $display("[TB] reset mid-frame");
    out_ready = 1'b1;
    do_reset();
    frames_done = 0;
    exp_q.push_back(0);
    for (int v = 0; v < 256; v++) apply_sample(v, STRIDE);
    idle(10);
    check_output("pre_reset_valid", int'(out_valid), 1);
    rst = 1'b1;
    idle(1);
    check_output("mid_rst_valid", int'(out_valid), 0);
    check_output("mid_rst_sample", int'(out_sample), 0);
    check_output("mid_rst_first", int'(out_first), 0);
    rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(1000);
    frames_done = 0;
    for (int n = 0; n < 255; n++) apply_sample(1000 + n, STRIDE);
    check_output("post_rst_no_frame", int'(out_valid), 0);
    write_sample(1255);
    check_output("post_rst_t1_valid", int'(out_valid), 0);
    idle(1);
    check_output("post_rst_t2_valid", int'(out_valid), 1);
    check_output("post_rst_sample", int'(out_sample), 1000);
    idle(STRIDE - 2);
    wait_frames(1, "post_rst_frames");
    check_output("post_rst_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
